// File: rtl/palette_ram.sv
// Writable NES-style palette RAM with self-clearing init sequencer, sprite-transparent mirroring and write-first read bypass.
// Optional grayscale read masking is enabled with the PALETTE_GRAYSCALE_EN macro (adds the gray input).
module palette_ram #(
  parameter int                ADDR_W     = 5,
  parameter int                DATA_W     = 6,
  parameter logic [DATA_W-1:0] INIT_COLOR = 6'h0F,
  parameter int                MIRROR_EN  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_req,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
`ifdef PALETTE_GRAYSCALE_EN
  ,
  input  logic              gray
`endif
);

  localparam int              DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   cnt_reg, cnt_next;
  logic [DATA_W-1:0] rd_data_reg;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] wr_map, rd_map;
  logic              wr_hit;
  logic              gray_sel;
  logic [DATA_W-1:0] gray_mask, rd_mask;

  // Upper-half entries with low bits 00 are the transparent sprite slots; they share the background entry.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] a);
    map_addr = a;
    if (MIRROR_EN != 0 && a[ADDR_W-1] && a[1:0] == 2'b00)
      map_addr[ADDR_W-1] = 1'b0;
  endfunction

  assign wr_map = map_addr(wr_addr);
  assign rd_map = map_addr(rd_addr);

`ifdef PALETTE_GRAYSCALE_EN
  assign gray_sel = gray;
`else
  assign gray_sel = 1'b0;
`endif

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_gray_mask
    assign gray_mask[gi] = (gi >= DATA_W - 2);
  end

  assign rd_mask  = gray_sel ? gray_mask : '1;
  assign busy     = (state_reg == S_INIT);
  assign wr_ready = ~busy;
  assign rd_data  = rd_data_reg;
  assign wr_hit   = (state_reg == S_RUN) && wr_en && (wr_map == rd_map);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_INIT;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mem_we     = 1'b0;
    mem_waddr  = wr_map;
    mem_wdata  = wr_data;
    case (state_reg)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_reg[ADDR_W-1:0];
        mem_wdata = INIT_COLOR;
        if (cnt_reg == CNT_LAST) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      S_RUN: begin
        // A write coinciding with init_req still lands before the clear starts.
        mem_we = wr_en;
        if (init_req) begin
          state_next = S_INIT;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = S_INIT;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n && mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      rd_data_reg <= INIT_COLOR;
    else if (busy)
      rd_data_reg <= INIT_COLOR;
    else if (wr_hit)
      rd_data_reg <= wr_data & rd_mask;
    else
      rd_data_reg <= mem[rd_map] & rd_mask;
  end

endmodule

// File: doc/palette_ram.md
Name: palette_ram

Overview:
- Writable, parametrised successor of the fixed palette ROMs.
- Holds the NES-style palette: one background half and one sprite half of colour indices. A CPU/PPU-register side writes entries; the pixel pipeline reads with 1-cycle registered latency.
- Adds three things a fixed ROM cannot provide: a self-clearing init sequencer, hardware mirroring of the "transparent" sprite entries, and write-first read bypass.
- Sits between the PPU register file ($3F00-$3F1F writes) and the colour-to-RGB lookup.

Parameters:
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries (minimum 3).
- DATA_W, 6, colour-index width (NES master palette index).
- INIT_COLOR, 6'h0F, value written to every entry by the init sequencer (black).
- MIRROR_EN, 1, 1 = entries with MSB set and low two bits 00 alias to the same address with MSB cleared.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- init_req  in  1  1-cycle pulse in RUN restarts the clear sequence.
- busy  out  1  high while the init sequencer runs.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address (pre-mirroring).
- wr_data  in  DATA_W  write data.
- wr_ready  out  1  high when writes are accepted (equals ~busy).
- rd_addr  in  ADDR_W  read address (pre-mirroring).
- rd_data  out  DATA_W  registered read data, valid 1 cycle after rd_addr.
- gray  in  1  grayscale select; present only with PALETTE_GRAYSCALE_EN.

Behaviour:
- Reset: synchronous, active-low (rst_n=0 sampled at posedge clk). State goes to INIT, init counter to 0, busy=1, wr_ready=0, rd_data=INIT_COLOR.
- Address mapping: map(a) = a with bit ADDR_W-1 cleared when MIRROR_EN=1, a[ADDR_W-1]=1 and a[1:0]=2'b00; otherwise map(a) = a. The mapping is applied to both ports.
  - Example (ADDR_W=5): 0x10, 0x14, 0x18 and 0x1C alias to 0x00, 0x04, 0x08 and 0x0C.
- FSM states:
  - INIT:
    - Each cycle write INIT_COLOR to entry cnt, then cnt++.
    - When cnt = DEPTH-1 is written, go to RUN next cycle. INIT therefore lasts exactly DEPTH cycles.
    - Aliased entries are written too; this is harmless.
  - RUN:
    - busy=0, wr_ready=1.
    - init_req=1 returns to INIT with cnt=0 on the next cycle.
- Writes:
  - In RUN, wr_en=1 stores wr_data at map(wr_addr) at that posedge.
  - In INIT, wr_en is ignored and the data is dropped; no queueing.
  - If wr_en and init_req are high in the same cycle, the write is performed, then INIT starts.
- Reads:
  - rd_data <= mem[map(rd_addr)] every cycle (1-cycle latency, no enable).
  - Write-first: if wr_en is accepted and map(wr_addr) = map(rd_addr) in the same cycle, rd_data takes wr_data. This includes aliased pairs, e.g. write 0x10 while reading 0x00.
  - While busy=1, rd_data is forced to INIT_COLOR.
- Reset during INIT or RUN: the sequence restarts from cnt=0 and memory contents are overwritten.
- Widths: cnt is ADDR_W+1 bits so termination cannot wrap. Address arithmetic wraps modulo DEPTH; no out-of-range addresses exist.

Optional Feature:
- Macro: PALETTE_GRAYSCALE_EN.
- Defined: the gray input exists. When gray=1 at the read posedge, the registered rd_data = mem value AND {2'b11, {(DATA_W-2){1'b0}}}. This keeps only the luminance row (NES $2001 bit 0 behaviour), and applies to the bypass path as well. The busy override still returns INIT_COLOR unmasked.
- Undefined: no gray port; rd_data is unmasked.

Test Plan:
- Reset then idle: busy=1 for exactly 32 cycles (DEPTH=32), wr_ready=0, rd_data=0x0F throughout. Afterwards, reads of 0x00..0x1F all return 0x0F.
- After init, write 0x00=0x22, 0x01=0x29, 0x11=0x16 -> reads return 0x22, 0x29, 0x16 one cycle after the address is presented. Reading 0x10 returns 0x22 (mirror).
- Write 0x1C=0x30, then read 0x0C -> 0x30. With MIRROR_EN=0, reading 0x0C -> 0x0F and reading 0x1C -> 0x30.
- Same-cycle write 0x05=0x36 with rd_addr=0x05 -> rd_data=0x36 next cycle (bypass). Repeat with write 0x14, read 0x04 -> bypass via alias.
- Write during busy (wr_addr=0x03, wr_data=0x17) -> ignored, so a later read of 0x03 returns 0x0F. Pulse init_req in RUN after writing 0x02=0x1A -> busy for 32 cycles, then 0x02 reads 0x0F. Drop rst_n at cycle 10 of INIT -> busy stays high for a full 32 cycles after release.
- With PALETTE_GRAYSCALE_EN: entry 0x01=0x29 with gray=1 -> rd_data=0x20; with gray=0 -> 0x29.
